inst_axi_rd_bridge: RTL and testbench
=====================================

# inst_axi_rd_bridge

Responder end of the instruction-fetch SRAM-like interface (`req`/`addr_ok`/`data_ok`).
- Accepts fetch requests from the IF stage and turns each one into a single-beat AXI4 read.
- Returns each response to IF as a one-cycle `data_ok` pulse carrying the instruction word.
- Sits between the IF stage and the top-level AXI read arbiter.
- Responses come back in request order. Up to `MAX_OUTST` requests may be in flight at once.

## Interface
Parameters:
- `MAX_OUTST`, 2, maximum accepted-but-unreturned requests; legal range 1..7.
- `AXI_ID`, 4'h0, constant `arid` for instruction reads.

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high reset.
- `inst_sram_req` in 1: fetch request.
- `inst_sram_wr` in 1: must be 0; the bridge ignores it and always performs a read.
- `inst_sram_wstrb` in 4: ignored.
- `inst_sram_wdata` in 32: ignored.
- `inst_sram_addr` in 32: physical fetch address.
- `inst_sram_addr_ok` out 1: request accepted this cycle.
- `inst_sram_data_ok` out 1: instruction valid this cycle.
- `inst_sram_rdata` out 32: instruction word.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arlock` out 2, `arcache` out 4, `arprot` out 3: AXI read-address fields.
- `arvalid` out 1, `arready` in 1: AXI read-address handshake.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1: AXI read-data fields.
- `rvalid` in 1, `rready` out 1: AXI read-data handshake.

## Operation
- AR FSM has two states, `AR_IDLE` and `AR_BUSY`.
  - `AR_IDLE` -> `AR_BUSY` on accept. On accept, register `araddr <= inst_sram_addr`.
  - `AR_BUSY` -> `AR_IDLE` on `arvalid & arready`.
  - `arvalid` is 1 exactly in `AR_BUSY`.
- Accept rule: `addr_ok = inst_sram_req & (state==AR_IDLE) & (outst_cnt < MAX_OUTST)`. `addr_ok` is combinational in the same cycle as `req`.
- Constant AR fields: `arid=AXI_ID`, `arlen=0`, `arsize=3'b010`, `arburst=2'b01`, `arlock=0`, `arcache=0`, `arprot=0`.
- `araddr` is held stable while `arvalid` is 1.
- `rready` is constantly 1. IF never backpressures `data_ok`.
- On `rvalid & rready` at cycle T:
  - `data_ok` = 1 at T+1.
  - `inst_sram_rdata <= rdata` at T+1.
  - `rresp` errors are ignored; the data is still returned.
  - `rid` and `rlast` are not checked.
- Outstanding counter `outst_cnt` has width clog2(MAX_OUTST+1):
  - +1 on accept.
  - −1 on R handshake.
  - Both in the same cycle: unchanged.
  - The counter never exceeds `MAX_OUTST` and never underflows. An R handshake while `outst_cnt==0` is a protocol violation; assert it in simulation.
- Full (`outst_cnt==MAX_OUTST`): `addr_ok`=0 even in `AR_IDLE`. A response in the same cycle does not free the slot until the next cycle.
- Cancellation is owned by IF. The bridge returns every accepted request and never drops or merges responses.

## Timing
- Reset values: `addr_ok`=0, `data_ok`=0, `inst_sram_rdata`=0, `arvalid`=0, `araddr`=0, `rready`=1; state `AR_IDLE`; `outst_cnt`=0.
- Reset asserted mid-transaction clears all state on the next edge. AXI slaves are reset in the same domain, so no stale R beats are expected after reset.
- Minimum latency with `arready`=1 and a slave that answers one cycle after AR:
  - accept at T, `arvalid` at T+1, `rvalid` at T+2, `data_ok` at T+3.
- Back-to-back accepts: next accept is possible at T+2 (the cycle after AR handshake at T+1). Sustained rate is one request per 2 cycles.
- `data_ok` can pulse on consecutive cycles if the slave returns beats back-to-back.
- `data_ok` may coincide with `addr_ok` in the same cycle.

## Structure
- Shared package `axi_pkg` holds:
  - AR constants: `ARSIZE_WORD=3'b010`, `ARBURST_INCR=2'b01`.
  - `AR_IDLE`/`AR_BUSY` state encoding.
  - `INST_AXI_ID`.
- Single module; no sub-module. The counter and FSM are small enough to stay inline.
- A data-side bridge will reuse the same package later.

## Test plan
- **Single fetch:** `req`, addr 32'h1c000000 at cycle 0, `arready`=1, slave returns 32'h02800000 one cycle after AR -> `addr_ok` at 0, `arvalid` at 1 with `araddr`=32'h1c000000, `data_ok` at 3 with rdata=32'h02800000.
- **AR stall:** `arready` held 0 for 5 cycles -> `arvalid`/`araddr` stable throughout, `addr_ok`=0 for a second `req`, accepted one cycle after AR handshake.
- **Full:** `MAX_OUTST`=2, two requests accepted, slave withholds R -> third `req` gets `addr_ok`=0 until the cycle after the first R handshake.
- **Ordering:** addresses 0x1c000000, 0x1c000004 with replies 0xAAAA0001, 0xAAAA0002 -> `data_ok` pulses return in that order with matching data, `outst_cnt` back to 0.
- **Error response:** `rresp`=2'b10 with rdata 0x12345678 -> `data_ok` pulses with 0x12345678, counter decrements.
- **Mid-flight reset:** `reset` during `AR_BUSY` with one outstanding -> next cycle `arvalid`=0, `outst_cnt`=0, `data_ok`=0, new `req` accepted immediately after reset deasserts.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 read-side definitions for the instruction and data bridges.
// Holds the AR-channel constants and the AR handshake state encoding.
package axi_pkg;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_t;

    localparam logic [2:0] ARSIZE_WORD  = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [3:0] INST_AXI_ID  = 4'h0;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch SRAM-like to single-beat AXI4 read bridge.
// In-order responses, up to MAX_OUTST fetches in flight.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   AR_IDLE | no AR pending; a new fetch may be accepted
//   AR_BUSY | arvalid high, holding araddr until arready
module inst_axi_rd_bridge
    import axi_pkg::*;
#(
    parameter int          MAX_OUTST = 2,
    parameter logic [3:0]  AXI_ID    = INST_AXI_ID
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int              CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ar_state_t        state_q, state_d;
    logic [CNT_W-1:0] outst_cnt;
    logic             accept;
    logic             r_hs;

    // Write-side inputs and unchecked R fields are intentionally dropped.
    logic unused_ok;
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

    assign accept = inst_sram_req & ~reset & (state_q == AR_IDLE) & (outst_cnt < CNT_MAX);
    assign r_hs   = rvalid & rready;

    assign inst_sram_addr_ok = accept;
    assign arvalid           = (state_q == AR_BUSY);
    assign rready            = 1'b1;

    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arsize  = ARSIZE_WORD;
    assign arburst = ARBURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            AR_IDLE: if (accept)  state_d = AR_BUSY;
            AR_BUSY: if (arready) state_d = AR_IDLE;
            default: state_d = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= AR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            araddr <= 32'd0;
        end else if (accept) begin
            araddr <= inst_sram_addr;
        end
    end

    // A response in the accept cycle frees its slot only from the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            outst_cnt <= '0;
        end else begin
            unique case ({accept, r_hs})
                2'b10:   outst_cnt <= outst_cnt + CNT_ONE;
                2'b01:   if (outst_cnt != '0) outst_cnt <= outst_cnt - CNT_ONE;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_sram_data_ok <= 1'b0;
            inst_sram_rdata   <= 32'd0;
        end else begin
            inst_sram_data_ok <= r_hs;
            if (r_hs) begin
                inst_sram_rdata <= rdata;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_orphan_r: assert property (@(posedge clk) disable iff (reset) r_hs |-> (outst_cnt != '0));
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scoreboard bench for inst_axi_rd_bridge: directed fetch scenarios, then
// randomized requests, arready and R timing against a queue-based model.
module tb_inst_axi_rd_bridge;

    localparam int         MAX_OUTST = 2;
    localparam logic [3:0] TB_ID     = 4'h5;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    inst_axi_rd_bridge #(.MAX_OUTST(MAX_OUTST), .AXI_ID(TB_ID)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Backing memory seen by the slave: instruction word as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] acc_q[$];
    logic [31:0] exp_q[$];
    int  m_outst   = 0;
    bit  m_busy    = 0;
    bit  m_rv_prev = 0;
    int  last_acc  = -1;
    int  last_arhs = -1;
    int  last_dok  = -1;
    int  rhs_first = -1;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk("addr_ok_in_reset", {31'd0, inst_sram_addr_ok}, 32'd0);
            acc_q.delete();
            exp_q.delete();
            m_outst   = 0;
            m_busy    = 0;
            m_rv_prev = 0;
        end else begin
            automatic bit exp_aok = inst_sram_req && !m_busy && (m_outst < MAX_OUTST);
            chk("addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, exp_aok});
            chk("arvalid", {31'd0, arvalid}, {31'd0, m_busy});
            if (arvalid) begin
                if (acc_q.size() == 0) begin
                    chk("ar_without_accept", 32'd1, 32'd0);
                end else begin
                    chk("araddr", araddr, acc_q[0]);
                end
                chk("ar_fields", {6'd0, arid, arlen, arsize, arburst, arlock, arcache, arprot},
                    {6'd0, TB_ID, 8'd0, 3'b010, 2'b01, 2'b00, 4'b0000, 3'b000});
                if (arready && acc_q.size() != 0) begin
                    void'(acc_q.pop_front());
                    m_busy    = 0;
                    last_arhs = cyc;
                end
            end
            chk("data_ok", {31'd0, inst_sram_data_ok}, {31'd0, m_rv_prev});
            if (inst_sram_data_ok) begin
                if (exp_q.size() == 0) begin
                    chk("data_without_request", 32'd1, 32'd0);
                end else begin
                    chk("rdata", inst_sram_rdata, exp_q.pop_front());
                end
                last_dok = cyc;
            end
            m_rv_prev = rvalid;
            if (rvalid) begin
                if (m_outst > 0) m_outst--;
                if (rhs_first < 0) rhs_first = cyc;
            end
            if (exp_aok) begin
                acc_q.push_back(inst_sram_addr);
                exp_q.push_back(mem_word(inst_sram_addr));
                m_outst++;
                m_busy   = 1;
                last_acc = cyc;
            end
        end
    end

    // ---------------- AXI slave ----------------
    // ar_mode: 0 arready low, 1 high, 2 random. r_mode: 0 withhold, 1 asap, 2 random.
    int          ar_mode = 1;
    int          r_mode  = 1;
    logic [31:0] slv_q[$];

    initial forever begin
        @(negedge clk);
        if (!reset && arvalid && arready) slv_q.push_back(araddr);
    end

    initial begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'd0;
        rresp   = 2'b00;
        rid     = 4'd0;
        rlast   = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                slv_q.delete();
                rvalid  = 1'b0;
                arready = 1'b0;
            end else begin
                case (ar_mode)
                    0:       arready = 1'b0;
                    1:       arready = 1'b1;
                    default: arready = 1'($urandom_range(0, 1));
                endcase
                case (r_mode)
                    0:       rvalid = 1'b0;
                    1:       rvalid = (slv_q.size() != 0);
                    default: rvalid = (slv_q.size() != 0) && ($urandom_range(0, 1) == 1);
                endcase
                rresp = 2'($urandom);
                rid   = 4'($urandom);
                if (rvalid) rdata = mem_word(slv_q.pop_front());
                else        rdata = $urandom;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [31:0] a);
        automatic bit got = 0;
        inst_sram_req  = 1'b1;
        inst_sram_addr = a;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok) got = 1;
            @(posedge clk);
            #1;
        end
        if (!got) chk("issue_timeout", 32'd0, 32'd1);
        inst_sram_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (m_outst != 0 || m_busy); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_outst", 32'(m_outst), 32'd0);
        chk("drain_expq", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        inst_sram_req   = 1'b0;
        inst_sram_wr    = 1'b0;
        inst_sram_wstrb = 4'd0;
        inst_sram_wdata = 32'd0;
        inst_sram_addr  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_rdata", inst_sram_rdata, 32'd0);
        chk("rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd1);
        @(posedge clk);
        #1;

        // single fetch, minimum latency
        ar_mode = 1; r_mode = 1;
        issue(32'h1c00_0000);
        repeat (5) @(posedge clk);
        #1;
        chk("lat_ar_hs", 32'(last_arhs - last_acc), 32'd1);
        chk("lat_data_ok", 32'(last_dok - last_acc), 32'd3);

        // AR stall with a second request waiting
        ar_mode = 0;
        issue(32'h1c00_0004);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0008;
        repeat (5) @(posedge clk);
        #1;
        ar_mode = 1;
        issue(32'h1c00_0008);
        chk("stall_reaccept", 32'(last_acc - last_arhs), 32'd1);
        drain();

        // full: two outstanding, R withheld
        r_mode = 0;
        issue(32'h1c00_0010);
        issue(32'h1c00_0014);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0018;
        repeat (4) @(posedge clk);
        #1;
        rhs_first = -1;
        r_mode    = 1;
        issue(32'h1c00_0018);
        chk("full_release", 32'(last_acc - rhs_first), 32'd1);
        drain();

        // reset while AR pending with one outstanding
        ar_mode = 0;
        issue(32'h1c00_0020);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0024;
        @(negedge clk);
        chk("midrst_araddr", araddr, 32'd0);
        chk("midrst_accept", {31'd0, inst_sram_addr_ok}, 32'd1);
        @(posedge clk);
        #1;
        inst_sram_req = 1'b0;
        ar_mode = 1;
        drain();

        // randomized traffic
        ar_mode = 2; r_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            inst_sram_req   = ($urandom_range(0, 2) != 0);
            inst_sram_addr  = $urandom & 32'hFFFF_FFFC;
            inst_sram_wr    = 1'b0;
            inst_sram_wstrb = 4'($urandom);
            inst_sram_wdata = $urandom;
            @(posedge clk);
            #1;
        end
        inst_sram_req = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
